// File: rtl/fp_mult_pkg.sv
// fp_mult_pkg: FP32 field layout and the requester tag carried alongside in-flight products.
package fp_mult_pkg;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_W    = 23;
    localparam int BIAS     = 127;
    localparam int MAX_ID_W = 4;

    typedef logic [31:0] fp32_t;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: N-way round-robin grant; the search starts at ptr, which moves past the winner on advance.
module rr_arbiter #(
    parameter int N = 4,
    localparam int ID_W = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grantIdx
);
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] idx;
    logic            found;

    always_comb begin
        grant    = '0;
        grantIdx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i >= N) ? ID_W'(int'(ptr) + i - N) : ID_W'(int'(ptr) + i);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grantIdx   = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ptr <= '0;
        else if (advance)
            ptr <= (int'(grantIdx) == N - 1) ? '0 : grantIdx + 1'b1;
    end
endmodule

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: round-robin front end for one shared FP32 multiplier; tags each launch with its
// requester ID and returns the product to that requester EXT_LAT+2 cycles after acceptance.
module fp_mult_arbiter
    import fp_mult_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int EXT_LAT = 0,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic [NUM_REQ-1:0]    req_ready,
    output fp32_t                 mul_a,
    output fp32_t                 mul_b,
    input  fp32_t                 mul_result,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [ID_W-1:0]       rsp_id,
    output fp32_t                 rsp_result,
    output logic                  busy
);
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantIdx;
    logic               accept;
    tag_t               tagPipe [EXT_LAT+1];
    logic [ID_W+2:0]    count;

    assign accept    = |grant;
    assign req_ready = grant;
    assign busy      = (count != '0);

    rr_arbiter #(.N(NUM_REQ)) uArb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .grantIdx(grantIdx)
    );

    // Operands are registered only on a grant so the multiplier inputs stay quiet while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a <= '0;
            mul_b <= '0;
            for (int i = 0; i <= EXT_LAT; i++)
                tagPipe[i] <= '0;
        end else begin
            if (accept) begin
                mul_a <= req_a[32*grantIdx +: 32];
                mul_b <= req_b[32*grantIdx +: 32];
            end
            tagPipe[0] <= tag_t'{valid: accept, id: MAX_ID_W'(grantIdx)};
            for (int i = 1; i <= EXT_LAT; i++)
                tagPipe[i] <= tagPipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            rsp_valid <= tagPipe[EXT_LAT].valid ? NUM_REQ'(1) << tagPipe[EXT_LAT].id : '0;
            if (tagPipe[EXT_LAT].valid) begin
                rsp_id     <= tagPipe[EXT_LAT].id[ID_W-1:0];
                rsp_result <= mul_result;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (accept && !(|rsp_valid))
            count <= count + 1'b1;
        else if (!accept && |rsp_valid)
            count <= count - 1'b1;
    end

    assert property (@(posedge clk) disable iff (!rst_n) !(|rsp_valid && !accept && count == '0));
endmodule

// File: tb/tb_fp_mult_arbiter.sv
// tb_fp_mult_arbiter: drives two arbiters (combinational and 3-stage multiplier) with identical stimulus
// and checks grants, responses, busy and operand hold against an accept-history reference model.
module tb_fp_mult_arbiter;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [3:0]   reqValid = '0;
    logic [31:0]  laneA [4];
    logic [31:0]  laneB [4];
    logic [127:0] reqA, reqB;

    logic [3:0]  rdy0, rdy3, rv0, rv3;
    logic [31:0] ma0, mb0, ma3, mb3, res0, res3, rr0, rr3;
    logic [31:0] s1, s2, s3;
    logic [1:0]  rid0, rid3;
    logic        busy0, busy3;

    int passCnt = 0;
    int totalCnt = 0;
    int k = 0;
    int ptr = 0;
    logic        hV   [2048];
    int          hId  [2048];
    logic [31:0] hRes [2048];
    logic [31:0] lastA, lastB;

    typedef struct {
        logic [3:0] v;
        logic [3:0] g;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    assign reqA = {laneA[3], laneA[2], laneA[1], laneA[0]};
    assign reqB = {laneB[3], laneB[2], laneB[1], laneB[0]};

    // Truncating FP32 multiply for normal operands; stands in for the external multiplier.
    function automatic logic [31:0] fpMul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0] p;
        logic [9:0]  e;
        p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        e = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127;
        if (p[47]) begin
            p = p >> 1;
            e = e + 10'd1;
        end
        return {a[31] ^ b[31], e[7:0], p[45:23]};
    endfunction

    function automatic logic [31:0] randFp();
        return {1'($urandom), 8'($urandom_range(96, 158)), 23'($urandom)};
    endfunction

    always_comb res0 = fpMul(ma0, mb0);
    always @(posedge clk) begin
        s1 <= fpMul(ma3, mb3);
        s2 <= s1;
        s3 <= s2;
    end
    assign res3 = s3;

    fp_mult_arbiter #(.NUM_REQ(4), .EXT_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_a(reqA), .req_b(reqB),
        .req_ready(rdy0), .mul_a(ma0), .mul_b(mb0), .mul_result(res0),
        .rsp_valid(rv0), .rsp_id(rid0), .rsp_result(rr0), .busy(busy0)
    );

    fp_mult_arbiter #(.NUM_REQ(4), .EXT_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(reqValid), .req_a(reqA), .req_b(reqB),
        .req_ready(rdy3), .mul_a(ma3), .mul_b(mb3), .mul_result(res3),
        .rsp_valid(rv3), .rsp_id(rid3), .rsp_result(rr3), .busy(busy3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s @cycle %0d: got %h expected %h", name, k, act, exp);
    endtask

    // Winner is the valid requester closest to ptr going upward with wrap.
    function automatic int modelGrant(input logic [3:0] v);
        int best = -1;
        for (int i = 0; i < 4; i++)
            if (v[i] && (best < 0 || (i - ptr + 4) % 4 < (best - ptr + 4) % 4))
                best = i;
        return best;
    endfunction

    task automatic checkDut(input string tag, input int lat, input logic [3:0] rv, input logic [1:0] rid,
                            input logic [31:0] rres, input logic bsy, input logic [31:0] ma, input logic [31:0] mb);
        int   c;
        logic expV, expBusy;
        c = k - lat - 2;
        expV = 1'b0;
        if (c >= 0) expV = hV[c];
        chk({tag, "_rsp_valid"}, 32'(rv), expV ? 32'(1 << hId[c]) : 32'd0);
        if (expV) begin
            chk({tag, "_rsp_id"}, 32'(rid), 32'(hId[c]));
            chk({tag, "_rsp_result"}, rres, hRes[c]);
        end
        expBusy = 1'b0;
        for (int j = k - lat - 2; j < k; j++)
            if (j >= 0 && hV[j]) expBusy = 1'b1;
        chk({tag, "_busy"}, 32'(bsy), 32'(expBusy));
        chk({tag, "_mul_a"}, ma, lastA);
        chk({tag, "_mul_b"}, mb, lastB);
    endtask

    task automatic step(input logic [3:0] v, input logic [3:0] expG, input bit useExp);
        int         g;
        logic [3:0] eg;
        reqValid = v;
        #1;
        g = modelGrant(v);
        eg = useExp ? expG : (g < 0 ? 4'd0 : 4'(1 << g));
        chk("dut0_req_ready", 32'(rdy0), 32'(eg));
        chk("dut3_req_ready", 32'(rdy3), 32'(eg));
        hV[k] = (g >= 0);
        if (g >= 0) begin
            hId[k] = g;
            hRes[k] = fpMul(laneA[g], laneB[g]);
            lastA = laneA[g];
            lastB = laneB[g];
            ptr = (g + 1) % 4;
        end
        @(posedge clk);
        #1;
        k++;
        checkDut("dut0", 0, rv0, rid0, rr0, busy0, ma0, mb0);
        checkDut("dut3", 3, rv3, rid3, rr3, busy3, ma3, mb3);
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'd0, 4'd0, 1'b1);
    endtask

    task automatic randLanes();
        for (int i = 0; i < 4; i++) begin
            laneA[i] = randFp();
            laneB[i] = randFp();
        end
    endtask

    task automatic checkQuiet(input string tag);
        chk({tag, "_dut0_rsp_valid"}, 32'(rv0), 32'd0);
        chk({tag, "_dut3_rsp_valid"}, 32'(rv3), 32'd0);
        chk({tag, "_dut0_busy"}, 32'(busy0), 32'd0);
        chk({tag, "_dut3_busy"}, 32'(busy3), 32'd0);
        chk({tag, "_dut0_mul_a"}, ma0, 32'd0);
        chk({tag, "_dut3_mul_b"}, mb3, 32'd0);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 2048; i++) hV[i] = 1'b0;
        ptr = 0;
        lastA = '0;
        lastB = '0;
    endtask

    task automatic rstPulse();
        reqValid = '0;
        rst_n = 1'b0;
        #1;
        checkQuiet("midreset");
        chk("midreset_dut0_rsp_result", rr0, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clearModel();
        k++;
    endtask

    initial begin
        int c0;
        for (int i = 0; i < 4; i++) begin
            laneA[i] = '0;
            laneB[i] = '0;
        end
        clearModel();
        repeat (2) @(posedge clk);
        #1;
        checkQuiet("reset");
        chk("reset_dut0_req_ready", 32'(rdy0), 32'd0);
        chk("reset_dut3_rsp_id", 32'(rid3), 32'd0);
        chk("reset_dut3_rsp_result", rr3, 32'd0);
        rst_n = 1'b1;
        k = 0;

        // Single request: 2.0 * 3.0 from requester 2.
        laneA[2] = 32'h40000000;
        laneB[2] = 32'h40400000;
        step(4'b0100, 4'b0100, 1'b1);
        idle(1);
        chk("single_rsp_valid", 32'(rv0), 32'b0100);
        chk("single_rsp_id", 32'(rid0), 32'd2);
        chk("single_rsp_result", rr0, 32'h40C00000);
        chk("single_busy_high", 32'(busy0), 32'd1);
        idle(1);
        chk("single_busy_low", 32'(busy0), 32'd0);
        idle(4);

        // Contention, pointer wrap/skip, repeated sole requester.
        tbl.push_back('{4'b1000, 4'b1000});
        repeat (2) begin
            tbl.push_back('{4'b1111, 4'b0001});
            tbl.push_back('{4'b1111, 4'b0010});
            tbl.push_back('{4'b1111, 4'b0100});
            tbl.push_back('{4'b1111, 4'b1000});
        end
        tbl.push_back('{4'b1010, 4'b0010});
        tbl.push_back('{4'b1010, 4'b1000});
        tbl.push_back('{4'b1010, 4'b0010});
        tbl.push_back('{4'b0001, 4'b0001});
        tbl.push_back('{4'b0001, 4'b0001});
        foreach (tbl[i]) begin
            randLanes();
            step(tbl[i].v, tbl[i].g, 1'b1);
        end
        idle(6);

        // 1.5 * 1.5 through the 3-stage multiplier, then interleaved 0/1 traffic.
        laneA[0] = 32'h3FC00000;
        laneB[0] = 32'h3FC00000;
        step(4'b0001, 4'b0001, 1'b1);
        idle(3);
        chk("lat3_early", 32'(rv3), 32'd0);
        idle(1);
        chk("lat3_rsp_valid", 32'(rv3), 32'b0001);
        chk("lat3_rsp_result", rr3, 32'h40100000);
        repeat (4) begin
            randLanes();
            step(4'b0011, 4'd0, 1'b0);
        end
        idle(6);

        // Reset while dut3 still has three products in flight.
        repeat (3) begin
            randLanes();
            step(4'b0111, 4'd0, 1'b0);
        end
        rstPulse();
        c0 = 0;
        repeat (8) begin
            step(4'd0, 4'd0, 1'b1);
            if (rv0 != 0 || rv3 != 0) c0++;
        end
        chk("reset_no_pulses", 32'(c0), 32'd0);
        randLanes();
        step(4'b1100, 4'b0100, 1'b1);
        idle(6);

        // Random bursts separated by 0-3 idle cycles, then free-running random valids.
        repeat (60) begin
            randLanes();
            step(4'($urandom_range(1, 15)), 4'd0, 1'b0);
            idle($urandom_range(0, 3));
        end
        repeat (200) begin
            if ($urandom_range(0, 1) == 0) randLanes();
            step(4'($urandom), 4'd0, 1'b0);
        end
        idle(6);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one FP32 multiplier datapath (IEEE-754 single, 24x24 mantissa product, biased-exponent add) among NUM_REQ requesters.
- Arbitrates operand requests round-robin and launches one multiply per cycle into the external multiplier.
- Tracks the requester ID through the multiplier latency and returns each product to its owner as a one-cycle pulse.
- Sits between the compute lanes and the single shared FP multiplier instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- EXT_LAT, 0, pipeline stages inside the attached multiplier (0 = combinational).
- ID_W, $clog2(NUM_REQ), requester ID width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester operand valid
- req_a  in  NUM_REQ*32  packed operand A, requester i at [32i+31:32i]
- req_b  in  NUM_REQ*32  packed operand B, same packing
- req_ready  out  NUM_REQ  one-hot grant; handshake = valid & ready
- mul_a  out  32  registered operand A to the multiplier
- mul_b  out  32  registered operand B to the multiplier
- mul_result  in  32  multiplier product, valid EXT_LAT cycles after mul_a/mul_b
- rsp_valid  out  NUM_REQ  one-hot, one-cycle result pulse
- rsp_id  out  ID_W  ID of the returning result
- rsp_result  out  32  product, broadcast to all requesters
- busy  out  1  high while any accepted request has not yet returned

Behaviour:
- Reset: all state clears asynchronously on rst_n low.
  - req_ready=0, mul_a=mul_b=0, rsp_valid=0, rsp_id=0, rsp_result=0, busy=0.
  - RR pointer=0. Tag pipeline valid bits=0.
- Arbitration (combinational):
  - Search req_valid starting at the RR pointer, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready is the one-hot winner, or 0 when no valid is set. req_ready depends on req_valid; requesters must not make req_valid depend on req_ready.
  - Asserted valids are not required to hold operands stable once granted.
- On handshake with winner w:
  - Next RR pointer = (w+1) mod NUM_REQ.
  - The pointer holds when there is no grant.
  - The pointer holds during reset.
- Launch stage (cycle T = accept edge): mul_a/mul_b <= req_a[w]/req_b[w]. Stage-0 tag <= {1, w}.
  - With no grant: tag valid <= 0, and mul_a/mul_b hold their last value.
- Tag pipeline: EXT_LAT registers shift {valid, id} every cycle, with no stall. There is no backpressure anywhere.
- Response stage: on the edge EXT_LAT+1 cycles after launch:
  - rsp_result <= mul_result.
  - rsp_id <= tag id.
  - rsp_valid <= onehot(id) if the tag is valid, else 0.
- Total latency from accept edge to rsp_valid high: EXT_LAT+2 cycles (2 for a combinational multiplier).
- Throughput: one accept per cycle sustained. A requester holding valid under full contention is granted at least once every NUM_REQ cycles.
- rsp_result/rsp_id hold their last value when rsp_valid=0. Consumers must qualify them with rsp_valid.
- busy = OR of all tag valid bits plus response-stage valid, plus the outstanding-count register.
  - Outstanding counter, width ID_W+3: +1 on accept, -1 on rsp_valid, unchanged when both occur in the same cycle.
  - busy = (count != 0).
  - The count never exceeds EXT_LAT+2. Overflow is impossible by construction. A debug assertion fires if the count decrements at 0.
- Simultaneous events:
  - The same requester may be granted in consecutive cycles when it is the only valid.
  - One accept and one response in the same cycle is normal.
- Reset mid-operation: all in-flight operations are dropped, no rsp_valid pulses follow, and the pointer returns to 0.
- The arithmetic is not re-implemented here. The external multiplier owns sign XOR, exponent add with bias 127, and normalisation.

Decomposition:
- Shared package fp_mult_pkg:
  - FP32 field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_W=23, BIAS=127.
  - typedef fp32_t (32-bit).
  - typedef tag struct {valid, id}.
- One natural sub-module: rr_arbiter (NUM_REQ-wide round-robin grant with pointer register and advance-on-grant input). It is reusable by the other shared datapath controllers.
- The tag shift pipeline stays inline.

Test Plan:
- Single request, EXT_LAT=0: req 2 sends a=0x40000000, b=0x40400000 (2.0*3.0) at cycle 0 -> req_ready=0b0100 in cycle 0; rsp_valid=0b0100, rsp_id=2, rsp_result=0x40C00000 at cycle 2; busy high for cycles 1-2.
- Full contention: all 4 valids held for 8 cycles -> grants 0,1,2,3,0,1,2,3 in order; 8 responses in the same order, back-to-back, 2 cycles behind.
- Pointer wrap and skip: valids {1,3} after the last grant to 3 -> next grant 1, then 3, then 1.
- EXT_LAT=3 with a 3-stage multiplier model: 1.5*1.5 (0x3FC00000 squared) from req 0 -> rsp 0x40100000 exactly 5 cycles after accept; interleaved requests from 0 and 1 -> IDs returned in issue order.
- Reset mid-flight: 3 requests accepted, rst_n pulsed low for 1 cycle before any response -> no rsp_valid pulses ever appear; busy=0 and pointer=0 after reset; the next request is granted to the lowest valid.
- Idle gaps: valid pulses with 0-3 idle cycles between them -> busy falls exactly 1 cycle after the final rsp_valid; mul_a/mul_b hold during idle cycles.
